// File: rtl/pkg_style.sv
// Shared pixel-pipeline types and defaults.
// Used by the 3x3 window generator and its line buffers.
package pkg_style;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef logic [PIX_W-1:0] pix_t;

    // Counter width for a dimension of n positions (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
// master drives the grey stream, slave is the generator.
interface window3x3_gen_if
    import pkg_style::*;
#(
    parameter int DW = PIX_W,
    parameter int XW = cnt_w(DEF_IMG_W),
    parameter int YW = cnt_w(DEF_IMG_H)
);

    logic          iSOF;
    logic          iDVAL;
    logic [DW-1:0] iGrey;

    logic [DW-1:0] oG00, oG01, oG02;
    logic [DW-1:0] oG10, oG11, oG12;
    logic [DW-1:0] oG20, oG21, oG22;
    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic          oDVAL;

    modport master (
        output iSOF, iDVAL, iGrey,
        input  oG00, oG01, oG02, oG10, oG11, oG12,
        input  oG20, oG21, oG22, oX, oY, oDVAL
    );

    modport slave (
        input  iSOF, iDVAL, iGrey,
        output oG00, oG01, oG02, oG10, oG11, oG12,
        output oG20, oG21, oG22, oX, oY, oDVAL
    );

endinterface

// File: rtl/linebuf_ram.sv
// One line of pixels, single port, read-before-write.
// Read data appears one cycle after an enabled access.
module linebuf_ram
    import pkg_style::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int DW    = PIX_W,
    parameter int AW    = cnt_w(DEF_IMG_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array: write only, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register: old contents of the addressed word, held when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// 3x3 window generator: raster grey stream in, one window per
// accepted pixel whose window lies fully inside the frame.
module window3x3_gen
    import pkg_style::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = PIX_W
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    window3x3_gen_if.slave bus
);

    localparam int XW = cnt_w(IMG_W);
    localparam int YW = cnt_w(IMG_H);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] col, col_in;
    logic [YW-1:0] row, row_in;
    logic          par, sel, win_ok;
    logic [DW-1:0] q0, q1, up2, up1;
    logic [DW-1:0] g00, g01, g10, g11, g20, g21, g22;
    logic          ovld;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    // Position of the incoming pixel; SOF forces it to (0,0).
    always_comb begin
        col_in = bus.iSOF ? '0 : col;
        row_in = bus.iSOF ? '0 : row;
    end

    // The two line RAMs alternate by row parity. The RAM of the current
    // parity returns row-2 and is overwritten with the new pixel; the
    // other one returns row-1. Same taps as a lb1->lb0 cascade, but
    // each RAM needs only one read-before-write port.
    assign par    = row_in[0];
    assign win_ok = (col_in >= XW'(2)) && (row_in >= YW'(2));
    assign up2    = sel ? q1 : q0;
    assign up1    = sel ? q0 : q1;

    linebuf_ram #(.DEPTH(IMG_W), .DW(DW), .AW(XW)) u_lb0 (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .en    (bus.iDVAL),
        .we    (bus.iDVAL & ~par),
        .addr  (col_in),
        .wdata (bus.iGrey),
        .rdata (q0)
    );

    linebuf_ram #(.DEPTH(IMG_W), .DW(DW), .AW(XW)) u_lb1 (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .en    (bus.iDVAL),
        .we    (bus.iDVAL & par),
        .addr  (col_in),
        .wdata (bus.iGrey),
        .rdata (q1)
    );

    // Raster counters: column wraps into the next row, row wraps per frame.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            col <= '0;
            row <= '0;
        end else if (bus.iDVAL) begin
            if (col_in == COL_LAST) begin
                col <= '0;
                row <= (row_in == ROW_LAST) ? '0 : row_in + 1'b1;
            end else begin
                col <= col_in + 1'b1;
                row <= row_in;
            end
        end
    end

    // Tap columns shift left on each pixel; new right column is RAM+input.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sel <= 1'b0;
            g00 <= '0;
            g01 <= '0;
            g10 <= '0;
            g11 <= '0;
            g20 <= '0;
            g21 <= '0;
            g22 <= '0;
        end else if (bus.iDVAL) begin
            sel <= par;
            g00 <= g01;
            g01 <= up2;
            g10 <= g11;
            g11 <= up1;
            g20 <= g21;
            g21 <= g22;
            g22 <= bus.iGrey;
        end
    end

    // Valid pulse and centre coordinates; coordinates hold between windows.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ovld <= 1'b0;
            ox   <= '0;
            oy   <= '0;
        end else begin
            ovld <= bus.iDVAL & win_ok;
            if (bus.iDVAL && win_ok) begin
                ox <= col_in - 1'b1;
                oy <= row_in - 1'b1;
            end
        end
    end

    assign bus.oG00  = g00;
    assign bus.oG01  = g01;
    assign bus.oG02  = up2;
    assign bus.oG10  = g10;
    assign bus.oG11  = g11;
    assign bus.oG12  = up1;
    assign bus.oG20  = g20;
    assign bus.oG21  = g21;
    assign bus.oG22  = g22;
    assign bus.oX    = ox;
    assign bus.oY    = oy;
    assign bus.oDVAL = ovld;

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen on a 4x4 frame.
// Reference: frame image array indexed by the raster position of each pixel.
module tb_window3x3_gen;
    import pkg_style::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XW = 2;
    localparam int YW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window3x3_gen_if #(.DW(PIX_W), .XW(XW), .YW(YW)) bus ();

    window3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(PIX_W)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    int           idx;
    pix_t         img [H][W];
    logic [71:0]  last_win;
    logic [XW-1:0] last_x;
    logic [YW-1:0] last_y;
    bit           hold_ok;
    int           pulses;
    int           ff_wins;
    bit           gauss_on;
    logic [71:0]  first_obs;
    logic [71:0]  final_obs;
    logic [3:0]   final_xy;

    function automatic logic [71:0] obs_win();
        return {bus.oG00, bus.oG01, bus.oG02,
                bus.oG10, bus.oG11, bus.oG12,
                bus.oG20, bus.oG21, bus.oG22};
    endfunction

    function automatic int gauss(input logic [71:0] w);
        int s;
        s = int'(w[71:64]) + 2 * int'(w[63:56]) + int'(w[55:48])
          + 2 * int'(w[47:40]) + 4 * int'(w[39:32]) + 2 * int'(w[31:24])
          + int'(w[23:16]) + 2 * int'(w[15:8]) + int'(w[7:0]);
        return (s + 8) >> 4;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idx      = 0;
        last_win = '0;
        last_x   = '0;
        last_y   = '0;
        hold_ok  = 1'b1;
    endtask

    // One clock: drive, predict from the image model, check after the edge.
    task automatic cyc(input bit sof, input bit dv, input pix_t g);
        bit          ev;
        int          r, c;
        logic [71:0] ew;
        bus.iSOF  = sof;
        bus.iDVAL = dv;
        bus.iGrey = g;
        ev = 1'b0;
        ew = '0;
        if (dv) begin
            if (sof) idx = 0;
            r = (idx / W) % H;
            c = idx % W;
            img[r][c] = g;
            ev = (r >= 2) && (c >= 2);
            if (ev) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew = {ew[63:0], img[r-2+i][c-2+j]};
                last_win = ew;
                last_x   = XW'(c - 1);
                last_y   = YW'(r - 1);
                hold_ok  = 1'b1;
            end else begin
                hold_ok = 1'b0;
            end
            idx++;
        end
        @(posedge clk);
        #1;
        chk("dval", 72'(bus.oDVAL), 72'(ev));
        if (ev) begin
            chk("win", obs_win(), ew);
            chk("xy", 72'({bus.oX, bus.oY}), 72'({last_x, last_y}));
            if (pulses == 0) first_obs = obs_win();
            final_obs = obs_win();
            final_xy  = {bus.oX, bus.oY};
            if (obs_win() == {9{8'hFF}}) ff_wins++;
            if (gauss_on) chk("gauss", 72'(gauss(obs_win())), 72'h80);
            pulses++;
        end else begin
            chk("xy_hold", 72'({bus.oX, bus.oY}), 72'({last_x, last_y}));
            if (hold_ok) chk("tap_hold", obs_win(), last_win);
        end
    endtask

    task automatic gaps(input int maxg);
        int n;
        n = $urandom_range(0, maxg);
        for (int k = 0; k < n; k++)
            cyc(1'($urandom), 1'b0, pix_t'($urandom));
    endtask

    function automatic pix_t pat(input int p, input int base);
        return pix_t'(base + 16 * (p / W) + (p % W));
    endfunction

    initial begin
        bus.iSOF  = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iGrey = '0;
        gauss_on  = 1'b0;
        pulses    = 0;
        ff_wins   = 0;
        first_obs = '0;
        final_obs = '0;
        final_xy  = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_win", obs_win(), '0);
        chk("rst_xy", 72'({bus.oX, bus.oY}), '0);
        chk("rst_dval", 72'(bus.oDVAL), '0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        // 1: continuous frame
        pulses = 0;
        for (int p = 0; p < W * H; p++) cyc(p == 0, 1'b1, pat(p, 0));
        cyc(1'b0, 1'b0, 8'h00);
        chk("t1_pulses", 72'(pulses), 72'd4);
        chk("t1_first", first_obs, 72'h00_01_02_10_11_12_20_21_22);
        chk("t1_last_g22", 72'(final_obs[7:0]), 72'h33);
        chk("t1_last_xy", 72'(final_xy), 72'({2'd2, 2'd2}));

        // 2: same frame with random gaps, SOF noise in gaps
        pulses = 0;
        for (int p = 0; p < W * H; p++) begin
            gaps(3);
            cyc(p == 0, 1'b1, pat(p, 0));
        end
        gaps(3);
        chk("t2_pulses", 72'(pulses), 72'd4);
        chk("t2_first", first_obs, 72'h00_01_02_10_11_12_20_21_22);

        // 3: back-to-back frames, second all 0xFF
        pulses = 0;
        for (int p = 0; p < W * H; p++) cyc(p == 0, 1'b1, pat(p, 8'h20));
        chk("t3a_pulses", 72'(pulses), 72'd4);
        pulses  = 0;
        ff_wins = 0;
        for (int p = 0; p < W * H; p++) cyc(p == 0, 1'b1, 8'hFF);
        chk("t3b_pulses", 72'(pulses), 72'd4);
        chk("t3b_ff", 72'(ff_wins), 72'd4);

        // 4: SOF at pixel (1,3)
        pulses = 0;
        for (int p = 0; p < W + 3; p++) cyc(p == 0, 1'b1, pat(p, 8'h90));
        for (int p = 0; p < W * H; p++) cyc(p == 0, 1'b1, pat(p, 8'h40));
        chk("t4_pulses", 72'(pulses), 72'd4);
        chk("t4_first", first_obs, 72'h40_41_42_50_51_52_60_61_62);

        // 5: reset mid-frame in row 2
        for (int p = 0; p < 2 * W + 1; p++) cyc(p == 0, 1'b1, pat(p, 8'h08));
        bus.iSOF  = 1'b0;
        bus.iDVAL = 1'b1;
        bus.iGrey = 8'hA5;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_win", obs_win(), '0);
        chk("t5_rst_dval", 72'({bus.oDVAL, bus.oX, bus.oY}), '0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("t5_rst_hold", 72'({bus.oDVAL, bus.oX, bus.oY}), '0);
            chk("t5_rst_taps", obs_win(), '0);
        end
        bus.iDVAL = 1'b0;
        model_reset();
        rst_n = 1'b1;
        pulses = 0;
        for (int p = 0; p < 3; p++) cyc(1'b0, 1'b1, pix_t'($urandom));
        chk("t5_pre_sof", 72'(pulses), 72'd0);
        for (int p = 0; p < W * H; p++) cyc(p == 0, 1'b1, pat(p, 8'h10));
        chk("t5_pulses", 72'(pulses), 72'd4);
        chk("t5_first", first_obs, 72'h10_11_12_20_21_22_30_31_32);

        // 6: constant image through the Gaussian kernel
        gauss_on = 1'b1;
        pulses = 0;
        for (int p = 0; p < W * H; p++) begin
            gaps(2);
            cyc(p == 0, 1'b1, 8'h80);
        end
        gauss_on = 1'b0;
        chk("t6_pulses", 72'(pulses), 72'd4);

        // 7: random pixels, two frames joined by counter wrap only
        pulses = 0;
        for (int p = 0; p < 2 * W * H; p++) begin
            gaps(3);
            cyc(p == 0, 1'b1, pix_t'($urandom));
        end
        gaps(3);
        chk("t7_pulses", 72'(pulses), 72'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
